// File: rtl/mmc3_scanline_irq_pkg.sv
// rtl/mmc3_scanline_irq_pkg.sv - shared constants for the MMC3 scanline IRQ block
//
// Holds the CPU register decode codes ({addr[15:13], addr[0]}), the save-state
// address map of the IRQ unit and the default A12 low-time qualification.
package mmc3_scanline_irq_pkg;

    localparam int A12_LOW_M2_DEFAULT = 3;

    typedef enum logic [3:0] {
        REG_C000 = 4'hC,   // reload value
        REG_C001 = 4'hD,   // request reload, clear counter
        REG_E000 = 4'hE,   // disable and acknowledge
        REG_E001 = 4'hF    // enable
    } reg_code_e;

    // Save-state bank 2 covers addresses 16-23; only 16-19 carry state.
    localparam logic [4:0] SST_IRQ_BANK   = 5'd2;
    localparam logic [7:0] SST_IRQ_RELOAD = 8'd16;
    localparam logic [7:0] SST_IRQ_COUNT  = 8'd17;
    localparam logic [7:0] SST_IRQ_FLAGS  = 8'd18;
    localparam logic [7:0] SST_IRQ_FILT   = 8'd19;

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// rtl/mmc3_scanline_irq_if.sv - save-state bus between the state manager and the IRQ block
//
// act    : save-state engine owns the block (normal operation frozen)
// we_reg : write strobe for the addressed save-state register
// addr   : save-state register address
// dato   : save-state write data
interface mmc3_scanline_irq_if;
    logic       act;
    logic       we_reg;
    logic [7:0] addr;
    logic [7:0] dato;

    modport master (output act, output we_reg, output addr, output dato);
    modport slave  (input  act, input  we_reg, input  addr, input  dato);
endinterface

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// rtl/mmc3_scanline_irq_a12_edge_filter.sv - PPU A12 rise qualifier for the scanline counter
//
// Ports:
//   clk, map_rst_n : clock and synchronous active-low reset
//   cpu_m2         : raw CPU M2 level, used as the low-time timebase
//   ppu_a12        : raw PPU A12, synchronised here
//   hold           : save-state active; freezes low-time count and blocks a12_clk
//   filt_we        : save-state write of the low-time count
//   filt_wdata     : value for that write
//   a12_clk        : one-cycle qualified A12 rise
//   filt_cnt       : current low-time count (for save-state readback)
module a12_edge_filter
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int A12_LOW_M2 = A12_LOW_M2_DEFAULT
) (
    input  logic       clk,
    input  logic       map_rst_n,
    input  logic       cpu_m2,
    input  logic       ppu_a12,
    input  logic       hold,
    input  logic       filt_we,
    input  logic [2:0] filt_wdata,
    output logic       a12_clk,
    output logic [2:0] filt_cnt
);

    localparam logic [2:0] LOW_LIM = 3'(A12_LOW_M2);

    logic       m2_prev;
    logic       a12_meta;
    logic       a12_sync;
    logic       a12_prev;
    logic [2:0] low_cnt;
    logic       m2_fall;
    logic       a12_rise;

    assign m2_fall  = m2_prev & ~cpu_m2;
    assign a12_rise = a12_sync & ~a12_prev;

    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            m2_prev  <= 1'b0;
            a12_meta <= 1'b0;
            a12_sync <= 1'b0;
            a12_prev <= 1'b0;
            low_cnt  <= 3'd0;
        end else begin
            // Edge and synchroniser flops run even during save-state so the
            // block resumes with fresh history.
            m2_prev  <= cpu_m2;
            a12_meta <= ppu_a12;
            a12_sync <= a12_meta;
            a12_prev <= a12_sync;
            if (filt_we) begin
                low_cnt <= filt_wdata;
            end else if (!hold) begin
                if (a12_sync) begin
                    low_cnt <= 3'd0;
                end else if (m2_fall && low_cnt < LOW_LIM) begin
                    low_cnt <= low_cnt + 3'd1;
                end
            end
        end
    end

    // The rise cycle still sees the low-time accumulated before A12 went high;
    // the clear lands one cycle later.
    assign a12_clk  = a12_rise & (low_cnt >= LOW_LIM) & ~hold;
    assign filt_cnt = low_cnt;

endmodule

// File: rtl/mmc3_scanline_irq.sv
// rtl/mmc3_scanline_irq.sv - MMC3 scanline counter and IRQ generator
//
// Ports:
//   clk, map_rst_n : clock and synchronous active-low mapper reset
//   decode_en      : CPU write strobe
//   reg_addr       : {cpu.addr[15:13], cpu.addr[0]}
//   cpu_data       : CPU write data
//   cpu_m2         : raw CPU M2
//   ppu_a12        : raw PPU A12
//   mmc3a          : 1 = MMC3A (old) IRQ behaviour, 0 = MMC3B/C (new)
//   sst            : save-state bus (slave side)
//   irq            : registered IRQ pending level
//   sst_ce         : save-state address falls in this block's bank (16-23)
//   sst_do         : save-state read data
module mmc3_scanline_irq
    import mmc3_scanline_irq_pkg::*;
#(
    parameter int A12_LOW_M2 = A12_LOW_M2_DEFAULT
) (
    input  logic                        clk,
    input  logic                        map_rst_n,
    input  logic                        decode_en,
    input  logic [3:0]                  reg_addr,
    input  logic [7:0]                  cpu_data,
    input  logic                        cpu_m2,
    input  logic                        ppu_a12,
    input  logic                        mmc3a,
    mmc3_scanline_irq_if.slave          sst,
    output logic                        irq,
    output logic                        sst_ce,
    output logic [7:0]                  sst_do
);

    logic [7:0] reload_val;
    logic [7:0] counter;
    logic       reload_flag;
    logic       irq_en;
    logic       irq_pend;

    logic       a12_clk;
    logic [2:0] filt_cnt;
    logic       filt_we;
    logic       reload_now;
    logic [7:0] cnt_next;
    logic       fire;
    reg_code_e  code;

    assign filt_we = sst.act & sst.we_reg & (sst.addr == SST_IRQ_FILT);

    a12_edge_filter #(
        .A12_LOW_M2 (A12_LOW_M2)
    ) u_filter (
        .clk        (clk),
        .map_rst_n  (map_rst_n),
        .cpu_m2     (cpu_m2),
        .ppu_a12    (ppu_a12),
        .hold       (sst.act),
        .filt_we    (filt_we),
        .filt_wdata (sst.dato[2:0]),
        .a12_clk    (a12_clk),
        .filt_cnt   (filt_cnt)
    );

    // A zero counter reloads instead of decrementing, so it never wraps.
    assign reload_now = (counter == 8'd0) || reload_flag;
    assign cnt_next   = reload_now ? reload_val : counter - 8'd1;
    // MMC3A refuses to fire when a zero counter merely reloads zero again.
    assign fire       = irq_en && (cnt_next == 8'd0) &&
                        (!mmc3a || (counter != 8'd0) || reload_flag);
    assign code       = reg_code_e'(reg_addr);

    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            reload_val  <= 8'd0;
            counter     <= 8'd0;
            reload_flag <= 1'b0;
            irq_en      <= 1'b0;
            irq_pend    <= 1'b0;
        end else if (sst.act) begin
            if (sst.we_reg) begin
                case (sst.addr)
                    SST_IRQ_RELOAD: reload_val <= sst.dato;
                    SST_IRQ_COUNT:  counter    <= sst.dato;
                    SST_IRQ_FLAGS: begin
                        reload_flag <= sst.dato[2];
                        irq_pend    <= sst.dato[1];
                        irq_en      <= sst.dato[0];
                    end
                    default: ;
                endcase
            end
        end else begin
            if (a12_clk) begin
                counter     <= cnt_next;
                reload_flag <= 1'b0;
                if (fire) begin
                    irq_pend <= 1'b1;
                end
            end
            // Register writes come after the clock so that a same-cycle C001
            // or E000 overrides it; C000 leaves cnt_next on the old value.
            if (decode_en) begin
                case (code)
                    REG_C000: reload_val <= cpu_data;
                    REG_C001: begin
                        counter     <= 8'd0;
                        reload_flag <= 1'b1;
                    end
                    REG_E000: begin
                        irq_en   <= 1'b0;
                        irq_pend <= 1'b0;
                    end
                    REG_E001: irq_en <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign irq    = irq_pend;
    assign sst_ce = (sst.addr[7:3] == SST_IRQ_BANK);

    always_comb begin
        sst_do = 8'hFF;
        case (sst.addr)
            SST_IRQ_RELOAD: sst_do = reload_val;
            SST_IRQ_COUNT:  sst_do = counter;
            SST_IRQ_FLAGS:  sst_do = {5'b0, reload_flag, irq_pend, irq_en};
            SST_IRQ_FILT:   sst_do = {5'b0, filt_cnt};
            default:        sst_do = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb/tb_mmc3_scanline_irq.sv - self-checking bench for mmc3_scanline_irq
module tb_mmc3_scanline_irq;

    logic       clk = 1'b0;
    logic       map_rst_n = 1'b0;
    logic       decode_en = 1'b0;
    logic [3:0] reg_addr = 4'h0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_m2 = 1'b0;
    logic       ppu_a12 = 1'b0;
    logic       mmc3a = 1'b0;
    logic       irq;
    logic       sst_ce;
    logic [7:0] sst_do;

    int checks = 0;
    int failures = 0;

    int exp_cnt_q[$];
    int exp_irq_q[$];

    mmc3_scanline_irq_if sst_bus ();

    mmc3_scanline_irq dut (
        .clk       (clk),
        .map_rst_n (map_rst_n),
        .decode_en (decode_en),
        .reg_addr  (reg_addr),
        .cpu_data  (cpu_data),
        .cpu_m2    (cpu_m2),
        .ppu_a12   (ppu_a12),
        .mmc3a     (mmc3a),
        .sst       (sst_bus),
        .irq       (irq),
        .sst_ce    (sst_ce),
        .sst_do    (sst_do)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        sst_bus.addr = a;
        #1;
        d = sst_do;
    endtask

    task automatic cpu_wr(input logic [3:0] code, input logic [7:0] d);
        decode_en = 1'b1;
        reg_addr  = code;
        cpu_data  = d;
        tick();
        decode_en = 1'b0;
    endtask

    task automatic sst_wr(input logic [7:0] a, input logic [7:0] d);
        sst_bus.we_reg = 1'b1;
        sst_bus.addr   = a;
        sst_bus.dato   = d;
        tick();
        sst_bus.we_reg = 1'b0;
    endtask

    // A12 low for nfalls M2 falling edges, then a rise. When inject is set,
    // a CPU write is placed in the exact cycle in which the rise is clocked.
    task automatic a12_pulse(input int nfalls, input bit inject,
                             input logic [3:0] code, input logic [7:0] d);
        ppu_a12 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < nfalls; i++) begin
            cpu_m2 = 1'b1;
            tick();
            cpu_m2 = 1'b0;
            tick();
        end
        ppu_a12 = 1'b1;
        tick();
        tick();
        if (inject) begin
            decode_en = 1'b1;
            reg_addr  = code;
            cpu_data  = d;
        end
        tick();
        decode_en = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        map_rst_n = 1'b0;
        sst_bus.act = 1'b0;
        sst_bus.we_reg = 1'b0;
        ppu_a12 = 1'b0;
        cpu_m2 = 1'b0;
        decode_en = 1'b0;
        tick();
        tick();
        map_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        sst_bus.act = 1'b0;
        sst_bus.we_reg = 1'b0;
        sst_bus.addr = 8'd0;
        sst_bus.dato = 8'd0;
        map_rst_n = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%0b want=0", irq);
        end
        map_rst_n = 1'b1;
        tick();
        for (int a = 16; a < 20; a++) begin
            rd(8'(a), d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL reset_sst_%0d got=%h want=00", a, d);
            end
        end
        rd(8'd21, d);
        checks++;
        if (d !== 8'hFF || sst_ce !== 1'b1) begin
            failures++;
            $display("FAIL sst_unused got=%h ce=%0b want=ff ce=1", d, sst_ce);
        end
        rd(8'd24, d);
        checks++;
        if (sst_ce !== 1'b0) begin
            failures++;
            $display("FAIL sst_ce_out got=%0b want=0", sst_ce);
        end
    endtask

    task automatic test_basic_count();
        logic [7:0] d;
        int seq_c[4] = '{2, 1, 0, 2};
        int seq_i[4] = '{0, 0, 1, 1};
        do_reset();
        mmc3a = 1'b0;
        cpu_wr(4'hC, 8'd2);
        cpu_wr(4'hD, 8'd0);
        cpu_wr(4'hF, 8'd0);
        for (int i = 0; i < 4; i++) begin
            exp_cnt_q.push_back(seq_c[i]);
            exp_irq_q.push_back(seq_i[i]);
            a12_pulse(3, 1'b0, 4'h0, 8'h00);
            rd(8'd17, d);
            checks++;
            if (int'(d) !== exp_cnt_q[0]) begin
                failures++;
                $display("FAIL basic_cnt[%0d] got=%0d want=%0d", i, d, exp_cnt_q[0]);
            end
            void'(exp_cnt_q.pop_front());
            checks++;
            if (int'(irq) !== exp_irq_q[0]) begin
                failures++;
                $display("FAIL basic_irq[%0d] got=%0b want=%0d", i, irq, exp_irq_q[0]);
            end
            void'(exp_irq_q.pop_front());
        end
    endtask

    task automatic test_glitch_filter();
        logic [7:0] d;
        do_reset();
        cpu_wr(4'hC, 8'd2);
        cpu_wr(4'hD, 8'd0);
        cpu_wr(4'hF, 8'd0);
        a12_pulse(2, 1'b0, 4'h0, 8'h00);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_cnt got=%0d irq=%0b want=0 irq=0", d, irq);
        end
        rd(8'd18, d);
        checks++;
        if (d !== 8'h05) begin
            failures++;
            $display("FAIL glitch_flags got=%h want=05", d);
        end
        a12_pulse(3, 1'b0, 4'h0, 8'h00);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd2) begin
            failures++;
            $display("FAIL glitch_after got=%0d want=2", d);
        end
    endtask

    task automatic test_modes(input logic old_mode);
        int seq_i[3];
        if (old_mode) seq_i = '{1, 0, 0};
        else          seq_i = '{1, 1, 1};
        do_reset();
        mmc3a = old_mode;
        cpu_wr(4'hC, 8'd0);
        cpu_wr(4'hD, 8'd0);
        cpu_wr(4'hF, 8'd0);
        for (int i = 0; i < 3; i++) begin
            exp_irq_q.push_back(seq_i[i]);
            a12_pulse(3, 1'b0, 4'h0, 8'h00);
            checks++;
            if (int'(irq) !== exp_irq_q[0]) begin
                failures++;
                $display("FAIL mode%0b_irq[%0d] got=%0b want=%0d", old_mode, i, irq, exp_irq_q[0]);
            end
            void'(exp_irq_q.pop_front());
            cpu_wr(4'hE, 8'd0);
            cpu_wr(4'hF, 8'd0);
        end
        mmc3a = 1'b0;
    endtask

    task automatic test_ack_race();
        logic [7:0] d;
        do_reset();
        cpu_wr(4'hC, 8'd1);
        cpu_wr(4'hD, 8'd0);
        cpu_wr(4'hF, 8'd0);
        a12_pulse(3, 1'b0, 4'h0, 8'h00);
        a12_pulse(3, 1'b1, 4'hE, 8'h00);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ack_race got cnt=%0d irq=%0b want cnt=0 irq=0", d, irq);
        end
        rd(8'd18, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL ack_race_flags got=%h want=00", d);
        end
    endtask

    task automatic test_write_races();
        logic [7:0] d;
        do_reset();
        cpu_wr(4'hC, 8'd4);
        cpu_wr(4'hD, 8'd0);
        a12_pulse(3, 1'b0, 4'h0, 8'h00);
        a12_pulse(3, 1'b1, 4'hD, 8'h00);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd0) begin
            failures++;
            $display("FAIL c001_race_cnt got=%0d want=0", d);
        end
        rd(8'd18, d);
        checks++;
        if (d !== 8'h04) begin
            failures++;
            $display("FAIL c001_race_flags got=%h want=04", d);
        end
        a12_pulse(3, 1'b1, 4'hC, 8'd9);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd4) begin
            failures++;
            $display("FAIL c000_race_cnt got=%0d want=4", d);
        end
        rd(8'd16, d);
        checks++;
        if (d !== 8'd9) begin
            failures++;
            $display("FAIL c000_race_reload got=%0d want=9", d);
        end
    endtask

    task automatic test_save_state();
        logic [7:0] d;
        do_reset();
        sst_bus.act = 1'b1;
        sst_wr(8'd16, 8'd5);
        sst_wr(8'd17, 8'd3);
        sst_wr(8'd18, 8'd3);
        rd(8'd18, d);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL sst_rd18 got=%h want=03", d);
        end
        // Rises during act must be ignored.
        a12_pulse(3, 1'b1, 4'hD, 8'h00);
        rd(8'd17, d);
        checks++;
        if (d !== 8'd3) begin
            failures++;
            $display("FAIL sst_hold_cnt got=%0d want=3", d);
        end
        sst_bus.act = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_cnt_q.push_back(2 - i);
            a12_pulse(3, 1'b0, 4'h0, 8'h00);
            rd(8'd17, d);
            checks++;
            if (int'(d) !== exp_cnt_q[0] || irq !== 1'b1) begin
                failures++;
                $display("FAIL sst_run[%0d] got cnt=%0d irq=%0b want cnt=%0d irq=1", i, d, irq, exp_cnt_q[0]);
            end
            void'(exp_cnt_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_count();
        logic [7:0] d;
        sst_bus.act = 1'b1;
        sst_wr(8'd16, 8'd9);
        sst_wr(8'd17, 8'd7);
        sst_wr(8'd18, 8'd3);
        sst_wr(8'd19, 8'd2);
        sst_bus.act = 1'b0;
        tick();
        rd(8'd17, d);
        checks++;
        if (d !== 8'd7 || irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got cnt=%0d irq=%0b want cnt=7 irq=1", d, irq);
        end
        map_rst_n = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL midrst_irq got=%0b want=0", irq);
        end
        for (int a = 16; a < 20; a++) begin
            rd(8'(a), d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL midrst_sst_%0d got=%h want=00", a, d);
            end
        end
        map_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_glitch_filter();
        test_modes(1'b0);
        test_modes(1'b1);
        test_ack_race();
        test_write_races();
        test_save_state();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
